// File: rtl/ps2_pkg.sv
// Shared decoder state, scan-code prefix/reply constants and frame geometry
// for the PS/2 keyboard receiver and decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } dec_state_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_FE = 8'hFE;

    localparam int FRAME_LEN  = 11;
    localparam int PAUSE_SKIP = 7;

    // Keyboard replies to host commands; they never carry a key event.
    function automatic logic is_reply(input logic [7:0] b);
        return (b == BYTE_FA) || (b == BYTE_AA) || (b == BYTE_EE) || (b == BYTE_FE);
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 line receiver: synchronizers, glitch filters, 11-bit frame capture and
// mid-frame timeout. Odd-parity checking is compiled in with PS2KEY_PARITY_EN.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILT    = 8,
    parameter int TIMEOUT = 49152
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(FILT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

    // Index 0 carries ps2_clk, index 1 carries ps2_data.
    logic [1:0]         meta;
    logic [1:0]         sync;
    logic [1:0]         filt;
    logic [1:0][CW-1:0] fcnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            meta <= '1;
            sync <= '1;
            filt <= '1;
            fcnt <= '0;
        end else begin
            meta <= {ps2_data, ps2_clk};
            sync <= meta;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILT - 1)) begin
                    filt[i] <= sync[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic          clk_prev;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] tcnt;
    logic          parity_ok;

    assign fall      = clk_prev & ~filt[0];
    assign byte_data = shreg;

`ifdef PS2KEY_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (fall && bit_cnt == LAST_BIT - 4'd1) begin
            parity_bit <= filt[1];
        end
    end

    assign parity_ok = ^{shreg, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_prev   <= 1'b1;
            bit_cnt    <= '0;
            shreg      <= '0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_prev   <= filt[0];
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (filt[1]) frame_err <= 1'b1;
                    else         bit_cnt   <= 4'd1;
                end else if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    if (filt[1] && parity_ok) byte_valid <= 1'b1;
                    else                      frame_err  <= 1'b1;
                end else begin
                    if (bit_cnt <= 4'd8) shreg <= {filt[1], shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // A falling edge in the same cycle takes the branch above.
                if (tcnt == TW'(TIMEOUT - 1)) begin
                    bit_cnt   <= '0;
                    tcnt      <= '0;
                    frame_err <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_gen.sv
// PS/2 scan-code decoder producing toggle-flagged key events with make/break
// and E0-extension flags. Parity checking in ps2_rx under PS2KEY_PARITY_EN.
module ps2_key_gen
    import ps2_pkg::*;
#(
    parameter int FILT    = 8,
    parameter int TIMEOUT = 49152
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    dec_state_t state, state_next;
    logic [2:0] skip_cnt, skip_next;
    logic       emit;

    ps2_rx #(
        .FILT    (FILT),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_data  (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= '0;
            ps2_key  <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
            err      <= frame_err;
            if (emit) begin
                ps2_key <= {~ps2_key[10],
                            (state == IDLE) || (state == EXT),
                            (state == EXT)  || (state == EXT_BRK),
                            rx_byte};
            end
        end
    end

    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        emit       = 1'b0;
        if (frame_err) begin
            if (state != SKIP) state_next = IDLE;
        end else if (byte_valid) begin
            case (state)
                IDLE: begin
                    if (rx_byte == BYTE_E0) begin
                        state_next = EXT;
                    end else if (rx_byte == BYTE_F0) begin
                        state_next = BRK;
                    end else if (rx_byte == BYTE_E1) begin
                        state_next = SKIP;
                        skip_next  = '0;
                    end else if (!is_reply(rx_byte)) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_byte == BYTE_F0)      state_next = EXT_BRK;
                    else if (rx_byte != BYTE_E0) emit = 1'b1;
                end
                BRK: begin
                    if (rx_byte != BYTE_F0) emit = 1'b1;
                end
                EXT_BRK: emit = 1'b1;
                SKIP: begin
                    if (skip_cnt == 3'(PAUSE_SKIP - 1)) begin
                        state_next = IDLE;
                        skip_next  = '0;
                    end else begin
                        skip_next = skip_cnt + 3'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
            if (emit) state_next = IDLE;
        end
    end

endmodule

// File: doc/ps2_key_gen.md
PS2_KEY_GEN -- requirements
Module: ps2_key_gen

Interface
REQ-001 SHALL have parameter FILT, default 8: consecutive equal samples a PS/2 line needs before its filtered value changes.
REQ-002 SHALL have parameter TIMEOUT, default 49152: idle clk_sys cycles allowed mid-frame (2 ms at 24.576 MHz).
REQ-003 SHALL have port clk_sys, input, 1 bit: single system clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw keyboard clock, asynchronous to clk_sys.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw keyboard data, asynchronous to clk_sys.
REQ-007 SHALL have port ps2_key, output, 11 bits, laid out as follows:
- [10]: toggles once per event.
- [9]: 1 = make, 0 = break.
- [8]: E0-extended.
- [7:0]: scan code.
REQ-008 SHALL have port err, output, 1 bit: one-cycle pulse per dropped frame.

Function
REQ-009 SHALL pass ps2_clk and ps2_data each through a 2-FF synchronizer, then a FILT-sample glitch filter; pulses shorter than FILT cycles are ignored.
REQ-010 SHALL sample filtered ps2_data on each filtered ps2_clk falling edge, with bit counter 0..10.
- Frame order: start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-011 SHALL drop the frame when start is not 0 or stop is not 1, pulsing err for one cycle.
REQ-012 SHALL, when the bit counter is non-zero and no falling edge occurs for TIMEOUT cycles, reset the counter to 0 and pulse err.
- If a falling edge and timeout expiry coincide, the edge wins.
REQ-013 SHALL make a received byte valid one cycle after the stop-bit edge; ps2_key SHALL update on the following cycle (2 cycles after the edge).
REQ-014 SHALL run a decoder FSM with states IDLE, EXT, BRK, EXT_BRK, SKIP. Transitions:
- IDLE, E0 -> EXT.
- IDLE, F0 -> BRK.
- EXT, F0 -> EXT_BRK.
- EXT, E0 -> stays EXT.
- BRK, F0 -> stays BRK.
- IDLE, E1 -> SKIP.
REQ-015 SHALL, in SKIP, discard the next 7 bytes (Pause sequence) using a 3-bit counter, then return to IDLE with no ps2_key update.
REQ-016 SHALL, on any other byte in any non-SKIP state, emit an event and return to IDLE:
- [9] = 1 if state is IDLE or EXT, else 0.
- [8] = 1 if state is EXT or EXT_BRK, else 0.
- [7:0] = the byte.
- [10] inverted.
REQ-017 SHALL ignore bytes FA (ack), AA (BAT pass), EE (echo) and FE (resend) received in IDLE; no event and no err.
REQ-018 SHALL return the FSM to IDLE when a frame is dropped (REQ-011, REQ-012, REQ-024) while in EXT, BRK or EXT_BRK.
REQ-019 SHALL hold ps2_key unchanged between events; at most one event per byte.

Reset
REQ-020 SHALL, on reset assertion, immediately clear:
- ps2_key to 11'h000 and err to 0;
- FSM to IDLE and bit counter, skip counter and timeout counter to 0;
- synchronizer and filter outputs to 1 (idle-high).
REQ-021 SHALL discard any partial frame or pending prefix when reset is asserted mid-operation.

Configuration
REQ-022 SHALL compile the parity check in only when PS2KEY_PARITY_EN is defined.
REQ-023 SHALL, without PS2KEY_PARITY_EN, sample the parity bit and ignore it.
REQ-024 SHALL, with PS2KEY_PARITY_EN, drop a byte whose 9 bits (data plus parity) have even weight, with an err pulse.

Structure
REQ-025 SHALL place the following in shared package ps2_pkg:
- decoder state enum;
- byte constants E0, F0, E1, FA, AA, EE, FE;
- frame length 11;
- Pause skip count 7.
REQ-026 SHALL implement synchronizer, filter, frame and timeout logic in sub-module ps2_rx (outputs byte, byte_valid, frame_err); ps2_key_gen holds the decoder FSM and output register.

Verification
REQ-027 SHALL verify: from reset, frame 0x29 with parity 0 -> ps2_key = 11'h629 two cycles after stop edge, err stays 0.
REQ-028 SHALL verify: E0 75 -> ps2_key = 11'h775; then E0 F0 75 -> 11'h175.
REQ-029 SHALL verify: frame 0x14 with wrong parity -> with macro, ps2_key unchanged and err high for 1 cycle; without macro, ps2_key = 11'h614.
REQ-030 SHALL verify: 4 bits sent, then idle for TIMEOUT+1 cycles -> err pulse; next frame 0x6B -> 11'h66B.
REQ-031 SHALL verify the following cases, each with the stated required result:
- 3-cycle low glitch on ps2_clk -> no bit counted.
- E1 followed by 7 bytes -> no event, FSM in IDLE.
- reset asserted after E0, then 0x6B -> 11'h66B (not extended).
